// File: rtl/lpc_io_target_if.sv
// LPC I/O target bus bundle: LPC pin side (LFRAME#, LAD split into in/out/oe)
// plus the register-file access port. The host/register-file model uses the
// master modport, the target uses the slave modport.
interface lpc_io_target_if;
  logic       LFRAME_N;
  logic [3:0] LadIn;
  logic [3:0] LadOut;
  logic       LadOe;
  logic [7:0] RdData;
  logic [7:0] Addr;
  logic       Wr;
  logic [7:0] DataWrSW;

  modport master (
    output LFRAME_N, LadIn, RdData,
    input  LadOut, LadOe, Addr, Wr, DataWrSW
  );

  modport slave (
    input  LFRAME_N, LadIn, RdData,
    output LadOut, LadOe, Addr, Wr, DataWrSW
  );
endinterface

// File: rtl/lpc_io_target.sv
// LPC I/O-cycle target. Decodes 1-byte I/O reads and writes that hit a
// 32-byte window at BASE_ADDR, drives the register-file port (Addr, Wr,
// DataWrSW) and returns RdData to the host over LAD. Every output is a flop
// loaded with the value it must carry in the following LPC clock.
module lpc_io_target #(
  parameter logic [15:0] BASE_ADDR = 16'h0800
) (
  input  logic              LpcClock,
  input  logic              PciReset,
  lpc_io_target_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CYC,
    S_ADDR,
    S_WDATA,
    S_HTAR,
    S_SYNC,
    S_RDATA,
    S_PTAR
  } state_t;

  state_t      state_q,    state_d;
  logic [1:0]  cnt_q,      cnt_d;       // nibble / clock index inside a state
  logic        dir_q,      dir_d;       // 1 = I/O write, 0 = I/O read
  logic [15:0] ioaddr_q,   ioaddr_d;
  logic [7:0]  addr_q,     addr_d;
  logic [7:0]  data_q,     data_d;
  logic [7:0]  rbuf_q,     rbuf_d;
  logic [3:0]  lad_out_q,  lad_out_d;
  logic        lad_oe_q,   lad_oe_d;
  logic        wr_q,       wr_d;

  // Next-state and next-output decode; outputs are computed for the clock
  // that follows the edge, so they land exactly in the cycle they belong to.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    ioaddr_d  = ioaddr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rbuf_d    = rbuf_q;
    lad_out_d = lad_out_q;
    lad_oe_d  = 1'b0;   // LAD is only driven where a state below says so
    wr_d      = 1'b0;   // Wr is a single-clock strobe

    if (!bus.LFRAME_N) begin
      // START wins in every state: the last LFRAME# sample decides, and any
      // cycle in progress (including a pending Wr) is abandoned.
      state_d = (bus.LadIn == 4'h0) ? S_CYC : S_IDLE;
      cnt_d   = 2'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d = 2'd0;
        end

        S_CYC: begin
          // 0000 = I/O read, 0010 = I/O write (bit 0 is reserved).
          if (bus.LadIn[3:2] == 2'b00) begin
            dir_d   = bus.LadIn[1];
            state_d = S_ADDR;
          end else begin
            state_d = S_IDLE;
          end
          cnt_d = 2'd0;
        end

        S_ADDR: begin
          ioaddr_d = {ioaddr_q[11:0], bus.LadIn};
          cnt_d    = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            cnt_d = 2'd0;
            if (ioaddr_d[15:5] == BASE_ADDR[15:5]) begin
              addr_d  = {3'b000, ioaddr_d[4:0]};
              state_d = dir_q ? S_WDATA : S_HTAR;
            end else begin
              state_d = S_IDLE;
            end
          end
        end

        S_WDATA: begin
          if (cnt_q == 2'd0) begin
            data_d[3:0] = bus.LadIn;
            cnt_d       = 2'd1;
          end else begin
            data_d[7:4] = bus.LadIn;
            cnt_d       = 2'd0;
            state_d     = S_HTAR;
          end
        end

        S_HTAR: begin
          if (cnt_q == 2'd0) begin
            cnt_d = 2'd1;
          end else begin
            // Last host-turnaround clock: Addr has been stable for a clock,
            // so the register file's RdData is valid to capture now.
            if (!dir_q) begin
              rbuf_d = bus.RdData;
            end
            cnt_d     = 2'd0;
            state_d   = S_SYNC;
            lad_oe_d  = 1'b1;
            lad_out_d = 4'h0;   // SYNC ready
            wr_d      = dir_q;
          end
        end

        S_SYNC: begin
          lad_oe_d = 1'b1;
          cnt_d    = 2'd0;
          if (dir_q) begin
            state_d   = S_PTAR;
            lad_out_d = 4'hF;
          end else begin
            state_d   = S_RDATA;
            lad_out_d = rbuf_q[3:0];
          end
        end

        S_RDATA: begin
          lad_oe_d = 1'b1;
          if (cnt_q == 2'd0) begin
            lad_out_d = rbuf_q[7:4];
            cnt_d     = 2'd1;
          end else begin
            lad_out_d = 4'hF;
            cnt_d     = 2'd0;
            state_d   = S_PTAR;
          end
        end

        S_PTAR: begin
          // First PTAR clock drove F; the second floats LAD, then idle.
          if (cnt_q == 2'd0) begin
            cnt_d = 2'd1;
          end else begin
            cnt_d   = 2'd0;
            state_d = S_IDLE;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // State and output registers; async reset returns all outputs at once.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 2'd0;
      dir_q     <= 1'b0;
      ioaddr_q  <= 16'h0000;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      rbuf_q    <= 8'h00;
      lad_out_q <= 4'hF;
      lad_oe_q  <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      ioaddr_q  <= ioaddr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rbuf_q    <= rbuf_d;
      lad_out_q <= lad_out_d;
      lad_oe_q  <= lad_oe_d;
      wr_q      <= wr_d;
    end
  end

  assign bus.LadOut   = lad_out_q;
  assign bus.LadOe    = lad_oe_q;
  assign bus.Addr     = addr_q;
  assign bus.Wr       = wr_q;
  assign bus.DataWrSW = data_q;

endmodule

// File: tb/tb_lpc_io_target.sv
// Directed bench for lpc_io_target: plays LFRAME#/LAD sequences one LPC
// clock at a time, records the outputs seen in each clock and compares them
// with hand-derived per-cycle expectations.
module tb_lpc_io_target;

  logic LpcClock;
  logic PciReset;

  lpc_io_target_if bus ();

  lpc_io_target #(.BASE_ADDR(16'h0800)) dut (
    .LpcClock (LpcClock),
    .PciReset (PciReset),
    .bus      (bus)
  );

  initial LpcClock = 1'b0;
  always #15 LpcClock = ~LpcClock;

  int n_checks = 0;
  int n_fails  = 0;

  // Stimulus queue: {LFRAME_N, LAD} per clock.
  logic [4:0] stim [$];

  // Outputs observed during each clock of the last run.
  logic       r_oe   [0:63];
  logic [3:0] r_out  [0:63];
  logic       r_wr   [0:63];
  logic [7:0] r_addr [0:63];
  logic [7:0] r_data [0:63];

  task automatic record(input int k);
    r_oe[k]   = bus.LadOe;
    r_out[k]  = bus.LadOut;
    r_wr[k]   = bus.Wr;
    r_addr[k] = bus.Addr;
    r_data[k] = bus.DataWrSW;
  endtask

  // Called 1 ns after a rising edge; leaves the bench 1 ns after an edge.
  task automatic run_stim();
    int n;
    n = stim.size();
    for (int k = 0; k < n; k++) begin
      record(k);
      {bus.LFRAME_N, bus.LadIn} = stim[k];
      @(posedge LpcClock);
      #1;
    end
    record(n);
    bus.LFRAME_N = 1'b1;
    bus.LadIn    = 4'hF;
    stim.delete();
  endtask

  // Queue the first len clocks of a host I/O cycle (START at index 0).
  task automatic push_io(input logic is_wr, input logic [15:0] a,
                         input logic [7:0] d, input int len);
    logic [4:0] v [0:12];
    v[0]  = {1'b0, 4'h0};
    v[1]  = {1'b1, (is_wr ? 4'h2 : 4'h0)};
    v[2]  = {1'b1, a[15:12]};
    v[3]  = {1'b1, a[11:8]};
    v[4]  = {1'b1, a[7:4]};
    v[5]  = {1'b1, a[3:0]};
    v[6]  = is_wr ? {1'b1, d[3:0]} : 5'h1F;
    v[7]  = is_wr ? {1'b1, d[7:4]} : 5'h1F;
    for (int i = 8; i < 13; i++) v[i] = 5'h1F;
    for (int i = 0; i < len && i < 13; i++) stim.push_back(v[i]);
    for (int i = 13; i < len; i++) stim.push_back(5'h1F);
  endtask

  task automatic test_reset();
    PciReset     = 1'b0;
    bus.LFRAME_N = 1'b1;
    bus.LadIn    = 4'hF;
    bus.RdData   = 8'h5A;
    #20;
    n_checks++;
    if (bus.LadOe !== 1'b0 || bus.LadOut !== 4'hF || bus.Wr !== 1'b0 ||
        bus.Addr !== 8'h00 || bus.DataWrSW !== 8'h00) begin
      n_fails++;
      $display("FAIL reset_values: got oe=%b out=%h wr=%b addr=%h data=%h required oe=0 out=f wr=0 addr=00 data=00",
               bus.LadOe, bus.LadOut, bus.Wr, bus.Addr, bus.DataWrSW);
    end
    @(posedge LpcClock);
    #1;
    PciReset = 1'b1;
    @(posedge LpcClock);
    #1;
  endtask

  task automatic test_write();
    push_io(1'b1, 16'h0808, 8'hA5, 14);
    run_stim();
    for (int k = 0; k <= 14; k++) begin
      n_checks++;
      if (r_wr[k] !== (k == 10)) begin
        n_fails++;
        $display("FAIL write_wr c%0d: got %b required %b", k, r_wr[k], (k == 10));
      end
      n_checks++;
      if (r_oe[k] !== (k == 10 || k == 11)) begin
        n_fails++;
        $display("FAIL write_oe c%0d: got %b required %b", k, r_oe[k], (k == 10 || k == 11));
      end
      if (k >= 6 && k <= 14) begin
        n_checks++;
        if (r_addr[k] !== 8'h08) begin
          n_fails++;
          $display("FAIL write_addr c%0d: got %h required 08", k, r_addr[k]);
        end
      end
    end
    n_checks++;
    if (r_data[10] !== 8'hA5) begin
      n_fails++;
      $display("FAIL write_data: got %h required a5", r_data[10]);
    end
    n_checks++;
    if (r_out[10] !== 4'h0 || r_out[11] !== 4'hF) begin
      n_fails++;
      $display("FAIL write_lad: got %h,%h required 0,f", r_out[10], r_out[11]);
    end
  endtask

  // Checks a read whose START was at absolute clock s of the last run.
  task automatic check_read(input string nm, input int s, input logic [7:0] rd,
                            input logic [7:0] a);
    logic [3:0] exp_out [0:3];
    exp_out[0] = 4'h0;
    exp_out[1] = rd[3:0];
    exp_out[2] = rd[7:4];
    exp_out[3] = 4'hF;
    for (int k = 0; k <= 13; k++) begin
      n_checks++;
      if (r_oe[s+k] !== (k >= 8 && k <= 11)) begin
        n_fails++;
        $display("FAIL %s_oe c%0d: got %b required %b", nm, k, r_oe[s+k], (k >= 8 && k <= 11));
      end
      n_checks++;
      if (r_wr[s+k] !== 1'b0) begin
        n_fails++;
        $display("FAIL %s_wr c%0d: got %b required 0", nm, k, r_wr[s+k]);
      end
      if (k >= 8 && k <= 11) begin
        n_checks++;
        if (r_out[s+k] !== exp_out[k-8]) begin
          n_fails++;
          $display("FAIL %s_lad c%0d: got %h required %h", nm, k, r_out[s+k], exp_out[k-8]);
        end
      end
    end
    n_checks++;
    if (r_addr[s+6] !== a) begin
      n_fails++;
      $display("FAIL %s_addr: got %h required %h", nm, r_addr[s+6], a);
    end
  endtask

  task automatic test_read();
    bus.RdData = 8'h5A;
    push_io(1'b0, 16'h081F, 8'h00, 14);
    run_stim();
    check_read("read", 0, 8'h5A, 8'h1F);
  endtask

  task automatic test_unmatched();
    // Unmatched I/O write, then a memory-read cycle type, then a good write.
    push_io(1'b1, 16'h0900, 8'hFF, 14);
    stim.push_back({1'b0, 4'h0});
    stim.push_back({1'b1, 4'h4});
    stim.push_back({1'b1, 4'h0});
    stim.push_back({1'b1, 4'h8});
    stim.push_back({1'b1, 4'h0});
    stim.push_back({1'b1, 4'h8});
    for (int i = 0; i < 8; i++) stim.push_back(5'h1F);
    push_io(1'b1, 16'h0801, 8'h3C, 14);
    run_stim();
    for (int k = 0; k < 28; k++) begin
      n_checks++;
      if (r_oe[k] !== 1'b0 || r_wr[k] !== 1'b0) begin
        n_fails++;
        $display("FAIL unmatched_quiet c%0d: got oe=%b wr=%b required 0,0", k, r_oe[k], r_wr[k]);
      end
    end
    n_checks++;
    if (r_addr[27] !== 8'h1F) begin
      n_fails++;
      $display("FAIL unmatched_addr_hold: got %h required 1f", r_addr[27]);
    end
    n_checks++;
    if (r_wr[38] !== 1'b1 || r_data[38] !== 8'h3C || r_addr[38] !== 8'h01) begin
      n_fails++;
      $display("FAIL after_unmatched_write: got wr=%b data=%h addr=%h required 1,3c,01",
               r_wr[38], r_data[38], r_addr[38]);
    end
  endtask

  task automatic test_abort();
    push_io(1'b1, 16'h0805, 8'h99, 7);
    stim.push_back({1'b0, 4'hF});         // abort in cycle 7
    push_io(1'b1, 16'h0804, 8'h77, 14);   // new START at absolute 8
    run_stim();
    for (int k = 0; k <= 21; k++) begin
      n_checks++;
      if (r_wr[k] !== (k == 18)) begin
        n_fails++;
        $display("FAIL abort_wr c%0d: got %b required %b", k, r_wr[k], (k == 18));
      end
      n_checks++;
      if (r_oe[k] !== (k == 18 || k == 19)) begin
        n_fails++;
        $display("FAIL abort_oe c%0d: got %b required %b", k, r_oe[k], (k == 18 || k == 19));
      end
    end
    n_checks++;
    if (r_data[18] !== 8'h77 || r_addr[18] !== 8'h04) begin
      n_fails++;
      $display("FAIL abort_restart_data: got data=%h addr=%h required 77,04", r_data[18], r_addr[18]);
    end
  endtask

  task automatic test_multi_start();
    bus.RdData = 8'h96;
    stim.push_back({1'b0, 4'hF});
    stim.push_back({1'b0, 4'hF});
    push_io(1'b0, 16'h0810, 8'h00, 14);   // third low clock carries LAD=0
    run_stim();
    check_read("mstart", 2, 8'h96, 8'h10);
    // LAD 0,0,F: last sample is not START, so the cycle is ignored.
    stim.push_back({1'b0, 4'h0});
    stim.push_back({1'b0, 4'h0});
    stim.push_back({1'b0, 4'hF});
    stim.push_back({1'b1, 4'h0});
    stim.push_back({1'b1, 4'h0});
    stim.push_back({1'b1, 4'h8});
    stim.push_back({1'b1, 4'h0});
    stim.push_back({1'b1, 4'h2});
    for (int i = 0; i < 8; i++) stim.push_back(5'h1F);
    run_stim();
    for (int k = 0; k <= 16; k++) begin
      n_checks++;
      if (r_oe[k] !== 1'b0 || r_wr[k] !== 1'b0) begin
        n_fails++;
        $display("FAIL mstart_ignored c%0d: got oe=%b wr=%b required 0,0", k, r_oe[k], r_wr[k]);
      end
    end
    n_checks++;
    if (r_addr[16] !== 8'h10) begin
      n_fails++;
      $display("FAIL mstart_ignored_addr: got %h required 10", r_addr[16]);
    end
  endtask

  task automatic test_back_to_back();
    bus.RdData = 8'h3E;
    push_io(1'b1, 16'h0802, 8'h11, 12);   // next START lands in cycle 12
    push_io(1'b0, 16'h0803, 8'h00, 14);
    run_stim();
    n_checks++;
    if (r_wr[10] !== 1'b1 || r_data[10] !== 8'h11 || r_addr[10] !== 8'h02) begin
      n_fails++;
      $display("FAIL b2b_write: got wr=%b data=%h addr=%h required 1,11,02",
               r_wr[10], r_data[10], r_addr[10]);
    end
    n_checks++;
    if (r_oe[12] !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_float: got oe=%b required 0", r_oe[12]);
    end
    check_read("b2b_read", 12, 8'h3E, 8'h03);
  endtask

  task automatic test_reset_mid_write();
    push_io(1'b1, 16'h0806, 8'hC3, 10);
    run_stim();                 // now inside cycle 10 (SYNC)
    n_checks++;
    if (bus.Wr !== 1'b1 || bus.LadOe !== 1'b1) begin
      n_fails++;
      $display("FAIL rst_pre_wr: got wr=%b oe=%b required 1,1", bus.Wr, bus.LadOe);
    end
    PciReset = 1'b0;
    #1;
    n_checks++;
    if (bus.LadOe !== 1'b0 || bus.Wr !== 1'b0 || bus.Addr !== 8'h00 ||
        bus.LadOut !== 4'hF || bus.DataWrSW !== 8'h00) begin
      n_fails++;
      $display("FAIL rst_async: got oe=%b wr=%b addr=%h out=%h data=%h required 0,0,00,f,00",
               bus.LadOe, bus.Wr, bus.Addr, bus.LadOut, bus.DataWrSW);
    end
    @(posedge LpcClock);
    #1;
    n_checks++;
    if (bus.Wr !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_wr_dropped: got %b required 0", bus.Wr);
    end
    PciReset = 1'b1;
    @(posedge LpcClock);
    #1;
    bus.RdData = 8'hC7;
    push_io(1'b0, 16'h0800, 8'h00, 14);
    run_stim();
    check_read("rst_read", 0, 8'hC7, 8'h00);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_unmatched();
    test_abort();
    test_multi_start();
    test_back_to_back();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/lpc_io_target.md
# lpc_io_target

LPC bus I/O-cycle target that decodes host LAD/LFRAME# traffic in a 32-byte I/O window and drives the register-file access port (Addr, Wr, DataWrSW). It returns read data (RdData) to the host over LAD. It sits between the LPC pins (tristate split at top level) and the LPC register file, on the 33 MHz LPC clock domain. It handles 1-byte I/O read and write cycles only; all other cycle types are ignored.

## Interface
- BASE_ADDR, 16'h0800, I/O window base; must be 32-byte aligned; window = BASE_ADDR..BASE_ADDR+0x1F
- LpcClock  in  1  33 MHz LPC clock; all logic on rising edge
- PciReset  in  1  asynchronous, active-low reset
- LFRAME_N  in  1  LPC frame, active low
- LadIn  in  4  LAD pins, input side
- LadOut  out  4  LAD drive value
- LadOe  out  1  LAD output enable (1 = drive)
- RdData  in  8  read data from the register file for the current Addr
- Addr  out  8  register offset {3'b000, ioaddr[4:0]}
- Wr  out  1  one-cycle write strobe to the register file
- DataWrSW  out  8  write data

## Operation
- States: IDLE, CYC, ADDR (nibble count 0–3), WDATA (0–1), HTAR (0–1), SYNC, RDATA (0–1), PTAR (0–1).
- START detection has priority in every state. On any edge with LFRAME_N=0:
  - next state = CYC if LadIn==4'h0, else IDLE.
  - LadOe is cleared on that same edge.
  - This covers multi-clock LFRAME# (the last sample wins) and host abort.
- CYC (LFRAME_N=1): LadIn[3:1] 3'b000 = I/O read, 3'b001 = I/O write, latched as dir. Any other value -> IDLE.
- ADDR: four nibbles, MSN first, shifted into a 16-bit ioaddr.
  - After the 4th nibble, match = (ioaddr[15:5] == BASE_ADDR[15:5]).
  - No match -> IDLE; LAD is never driven and Wr never fires.
  - Match -> Addr <= {3'b000, ioaddr[4:0]}. Addr holds until the next matched cycle.
  - Next state is WDATA for a write, HTAR for a read.
- WDATA: two nibbles, LSN first, into DataWrSW, then HTAR.
- HTAR: two clocks, host turnaround; LAD not driven.
- Read, second HTAR clock: RdData is captured into an internal read buffer.
- SYNC: one clock, LadOe=1, LadOut=4'h0. For a write, Wr=1 in this clock.
- RDATA (read only): LadOut = rbuf[3:0], then rbuf[7:4].
- PTAR: first clock LadOe=1, LadOut=4'hF; second clock LadOe=0. Then IDLE.
- Only SYNC, RDATA and PTAR clock 0 assert LadOe; LadOe is 0 in every other state.
- Reset values: state IDLE, LadOe 0, LadOut 4'hF, Addr 8'h00, Wr 0, DataWrSW 8'h00, read buffer 8'h00.
- Reset mid-cycle: all outputs return to reset values immediately (asynchronous). A pending Wr is dropped.

## Timing
- Cycle 0 = the clock where LFRAME_N=0 and LadIn=0 (START). Cycle 1 = CYCTYPE. Cycles 2–5 = address.
- All outputs are registered. "Cycle n" means the output is valid during clock n, having changed on the edge ending clock n-1.
- Addr is valid from cycle 6 for both directions.
- Write sequence:
  - cycles 6–7 data in;
  - cycles 8–9 host TAR;
  - cycle 10 SYNC (LadOe=1, 0000) and Wr=1, with Addr and DataWrSW stable;
  - cycle 11 LadOut=F, LadOe=1;
  - cycle 12 LadOe=0.
- Read sequence:
  - cycles 6–7 host TAR, RdData sampled at the end of cycle 7;
  - cycle 8 SYNC;
  - cycle 9 data LSN, cycle 10 data MSN;
  - cycle 11 F;
  - cycle 12 float.
- Wr is exactly one clock wide. Wr is never asserted for a read, an unmatched cycle, or an aborted cycle.
- Back-to-back cycles: a START in cycle 12 or later is accepted.
- A START before the end of PTAR aborts the current cycle. If it arrives before or in cycle 9 of a write, Wr does not fire.

## Test plan
- Write 0xA5 to 0x0808: Addr=0x08 from cycle 6; Wr=1 only in cycle 10 with DataWrSW=0xA5; LAD driven 0 (cycle 10), F (cycle 11); LadOe=0 from cycle 12.
- Read 0x081F with RdData=0x5A: LadOut 0 (cycle 8), A (cycle 9), 5 (cycle 10), F (cycle 11); LadOe low in cycles 0–7 and from cycle 12; Wr stays 0.
- Unmatched address 0x0900, and memory cycle type 4'b0100: LadOe and Wr stay 0 for the whole cycle; an immediately following matched write to 0x0801 succeeds.
- Abort: LFRAME_N=0 with LAD=F in cycle 7 of a write -> no Wr, LadOe 0; a START on the next clock starts a clean cycle and completes normally.
- Multi-clock START: LFRAME_N low for 3 clocks with LAD F,F,0 -> accepted, with cycle 0 = the third clock. LFRAME_N low with LAD 0,0,F -> ignored.
- Reset asserted in cycle 10 of a write -> LadOe=0, Wr=0, Addr=0x00 immediately; after release a read works.
